// File: rtl/test_pattern_checker.sv
// Receive-side checker for the hvsync test pattern: recovers hpos/vpos from sync edges,
// locks to the sync timing and counts pixels that deviate from the grid/stripe pattern.
module test_pattern_checker #(
   parameter int unsigned H_DISPLAY  = 256,
   parameter int unsigned H_TOTAL    = 309,
   parameter int unsigned V_DISPLAY  = 240,
   parameter int unsigned V_TOTAL    = 262,
   parameter int unsigned H_ALIGN    = 264,
   parameter int unsigned V_ALIGN    = 254,
   parameter int unsigned LOCK_LINES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [2:0]  rgb,
   input  logic        clr_err,
   output logic [8:0]  hpos,
   output logic [8:0]  vpos,
   output logic        display_on,
   output logic        locked,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [15:0] err_count
);

   localparam int unsigned GW = $clog2(LOCK_LINES + 1);

   typedef enum logic [1:0] {StSearch, StHTrack, StVWait, StLocked} state_e;

   state_e          state_q, state_d;
   logic            hs_q, hs_d, vs_q, vs_d;
   logic [2:0]      rgb_q;
   logic [8:0]      hpos_q, hpos_d, vpos_q, vpos_d;
   logic [GW-1:0]   good_q, good_d;
   logic [15:0]     err_q, err_d;
   logic            frame_err_q, frame_err_d;
   logic            frame_ok_q, frame_ok_d;
   logic            frame_done_q;

   logic            h_edge, v_edge, h_last, v_last, h_wrap, h_exp, h_good, h_bad, v_bad;
   logic            is_locked, disp, mismatch, frame_end;
   logic [2:0]      exp_rgb;

   always_comb begin
      h_edge = hs_q & ~hs_d;
      v_edge = vs_q & ~vs_d;
      h_last = (hpos_q == 9'(H_TOTAL - 1));
      v_last = (vpos_q == 9'(V_TOTAL - 1));
      // A reload on the last pixel of a line replaces the wrap, so no line advance.
      h_wrap = h_last & ~h_edge;
      h_exp  = (hpos_q == 9'(H_ALIGN - 1));
      h_good = h_edge & h_exp;
      h_bad  = h_edge ^ h_exp;
      v_bad  = v_edge ? (vpos_q != 9'(V_ALIGN - 1))
                      : (h_wrap & (vpos_q == 9'(V_ALIGN - 1)));
   end

   always_comb begin
      hpos_d = hpos_q;
      vpos_d = vpos_q;
      if (state_q == StSearch) begin
         if (h_edge) hpos_d = 9'(H_ALIGN);
      end else begin
         if (h_edge)      hpos_d = 9'(H_ALIGN);
         else if (h_last) hpos_d = 9'd0;
         else             hpos_d = hpos_q + 9'd1;
         if (v_edge)      vpos_d = 9'(V_ALIGN);
         else if (h_wrap) vpos_d = v_last ? 9'd0 : vpos_q + 9'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      unique case (state_q)
         StSearch: begin
            if (h_edge) begin
               state_d = StHTrack;
               good_d  = '0;
            end
         end
         StHTrack: begin
            if (h_bad) begin
               good_d = '0;
            end else if (h_good) begin
               good_d = good_q + GW'(1);
               if (good_q == GW'(LOCK_LINES - 1)) state_d = StVWait;
            end
         end
         StVWait: begin
            if (h_bad) begin
               state_d = StHTrack;
               good_d  = '0;
            end else if (v_edge) begin
               state_d = StLocked;
            end
         end
         StLocked: begin
            if (h_bad) begin
               state_d = StHTrack;
               good_d  = '0;
            end else if (v_bad) begin
               state_d = StVWait;
            end
         end
         default: state_d = StSearch;
      endcase
   end

   always_comb begin
      is_locked = (state_q == StLocked);
      // Counters sit at 0 while searching; keep display_on low so reset shows all zeros.
      disp      = (state_q != StSearch) && (hpos_q < 9'(H_DISPLAY)) && (vpos_q < 9'(V_DISPLAY));
      exp_rgb   = disp ? {hpos_q[4], vpos_q[4], (hpos_q[2:0] == 3'd0) | (vpos_q[2:0] == 3'd0)}
                       : 3'b000;
      mismatch  = is_locked && (rgb_q != exp_rgb);
      frame_end = is_locked && h_last && v_last;

      err_d = err_q;
      if (clr_err)                          err_d = 16'd0;
      else if (mismatch && err_q != 16'hFFFF) err_d = err_q + 16'd1;

      frame_err_d = frame_err_q;
      if (frame_end || (is_locked && state_d != StLocked)) frame_err_d = 1'b0;
      else if (mismatch)                                   frame_err_d = 1'b1;

      frame_ok_d = frame_end ? ~(frame_err_q | mismatch) : frame_ok_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_q         <= 1'b1;
         hs_d         <= 1'b1;
         vs_q         <= 1'b1;
         vs_d         <= 1'b1;
         rgb_q        <= 3'b000;
         state_q      <= StSearch;
         hpos_q       <= 9'd0;
         vpos_q       <= 9'd0;
         good_q       <= '0;
         err_q        <= 16'd0;
         frame_err_q  <= 1'b0;
         frame_ok_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         hs_q         <= hsync;
         hs_d         <= hs_q;
         vs_q         <= vsync;
         vs_d         <= vs_q;
         rgb_q        <= rgb;
         state_q      <= state_d;
         hpos_q       <= hpos_d;
         vpos_q       <= vpos_d;
         good_q       <= good_d;
         err_q        <= err_d;
         frame_err_q  <= frame_err_d;
         frame_ok_q   <= frame_ok_d;
         frame_done_q <= frame_end;
      end
   end

   assign hpos       = hpos_q;
   assign vpos       = vpos_q;
   assign display_on = disp;
   assign locked     = is_locked;
   assign frame_done = frame_done_q;
   assign frame_ok   = frame_ok_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_test_pattern_checker.sv
// Directed bench for test_pattern_checker using a shrunken raster so lock, slips and
// saturation all fit in a short run. The source model drives pins one clock per position.
module tb_test_pattern_checker;

   localparam int HD = 24;
   localparam int HT = 32;
   localparam int VD = 20;
   localparam int VT = 24;
   localparam int HA = 28;
   localparam int VA = 22;
   localparam int LL = 4;
   localparam int FRAME = HT * VT;
   // Source vsync rises on the last pixel of line VA-1 so the checker reloads VA at the wrap.
   localparam int VS0 = (VA - 1) * HT + HT - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hsync = 1'b0;
   logic        vsync = 1'b0;
   logic [2:0]  rgb = 3'b000;
   logic        clr_err = 1'b0;
   logic [8:0]  hpos, vpos;
   logic        display_on, locked, frame_done, frame_ok;
   logic [15:0] err_count;

   int checks = 0;
   int failures = 0;
   int src_h = 0, src_v = 0, drv_h = 0, drv_v = 0, last_h = 0, last_v = 0;
   int slip_v = -1;
   int fd_seen = 0;
   bit hold = 0, inj_r = 0, drop_vs = 0, force7 = 0;

   test_pattern_checker #(
      .H_DISPLAY(HD), .H_TOTAL(HT), .V_DISPLAY(VD), .V_TOTAL(VT),
      .H_ALIGN(HA), .V_ALIGN(VA), .LOCK_LINES(LL)
   ) dut (
      .clk(clk), .reset(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb), .clr_err(clr_err),
      .hpos(hpos), .vpos(vpos), .display_on(display_on), .locked(locked),
      .frame_done(frame_done), .frame_ok(frame_ok), .err_count(err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] pat(input int h, input int v);
      logic [2:0] p;
      p = 3'b000;
      if (h < HD && v < VD) begin
         p[2] = ((h / 16) % 2) == 1;
         p[1] = ((v / 16) % 2) == 1;
         p[0] = (h % 8 == 0) || (v % 8 == 0);
      end
      return p;
   endfunction

   task automatic drive_src();
      int hs0, f;
      logic [2:0] p;
      last_h = drv_h;
      last_v = drv_v;
      if (!hold) begin
         drv_h = src_h;
         drv_v = src_v;
         hs0 = (drv_v == slip_v) ? HA : HA - 1;
         hsync = (drv_h >= hs0) && (drv_h < hs0 + 3);
         f = drv_v * HT + drv_h;
         vsync = !drop_vs && (f >= VS0) && (f < VS0 + 2 * HT);
         p = pat(drv_h, drv_v);
         if (inj_r && drv_h == 9 && drv_v == 9) begin
            p[0] = 1'b1;
            inj_r = 0;
         end
         if (force7) p = 3'b111;
         rgb = p;
         if (src_h == HT - 1) begin
            src_h = 0;
            src_v = (src_v == VT - 1) ? 0 : src_v + 1;
         end else begin
            src_h = src_h + 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive_src();
      if (frame_done) fd_seen++;
   endtask

   task automatic run_to(input int h, input int v, output bit ok);
      ok = 0;
      for (int i = 0; i < 2 * FRAME && !ok; i++) begin
         step();
         if (last_h == h && last_v == v) ok = 1;
      end
   endtask

   task automatic wait_fd(output bit ok, output int n);
      ok = 0;
      n = 0;
      while (!ok && n < 2 * FRAME) begin
         step();
         n++;
         if (frame_done) ok = 1;
      end
   endtask

   task automatic wait_lock(output bit ok);
      ok = 0;
      for (int i = 0; i < 3 * FRAME && !ok; i++) begin
         step();
         if (locked) ok = 1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({hpos, vpos} !== 18'd0) begin
         failures++;
         $display("FAIL reset_pos hpos=%0d vpos=%0d expected 0 0", hpos, vpos);
      end
      checks++;
      if ({display_on, locked, frame_done, frame_ok} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b expected 0000",
                  {display_on, locked, frame_done, frame_ok});
      end
      checks++;
      if (err_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_err err_count=%0d expected 0", err_count);
      end
      rst = 1'b0;
   endtask

   task automatic test_lock();
      bit ok;
      wait_lock(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL lock_timeout locked=%b expected 1", locked);
      end
      checks++;
      if (last_h != 0 || last_v != VA) begin
         failures++;
         $display("FAIL lock_point at=(%0d,%0d) expected (0,%0d)", last_h, last_v, VA);
      end
      checks++;
      if (hpos !== 9'(last_h) || vpos !== 9'(last_v)) begin
         failures++;
         $display("FAIL lock_align hpos=%0d vpos=%0d expected %0d %0d",
                  hpos, vpos, last_h, last_v);
      end
   endtask

   task automatic test_frame_period();
      bit ok;
      int n;
      wait_fd(ok, n);
      checks++;
      if (!ok || last_h != 0 || last_v != 0 || frame_ok !== 1'b1) begin
         failures++;
         $display("FAIL frame_first ok=%b at=(%0d,%0d) frame_ok=%b expected 1 (0,0) 1",
                  ok, last_h, last_v, frame_ok);
      end
      wait_fd(ok, n);
      checks++;
      if (!ok || n != FRAME) begin
         failures++;
         $display("FAIL frame_period got=%0d expected %0d", n, FRAME);
      end
      checks++;
      if (err_count !== 16'd0 || frame_ok !== 1'b1) begin
         failures++;
         $display("FAIL frame_clean err=%0d frame_ok=%b expected 0 1", err_count, frame_ok);
      end
   endtask

   task automatic test_pixel_error();
      bit ok;
      int n;
      inj_r = 1;
      run_to(9, 9, ok);
      checks++;
      if (!ok || err_count !== 16'd0) begin
         failures++;
         $display("FAIL pix_before err=%0d expected 0", err_count);
      end
      step();
      checks++;
      if (err_count !== 16'd1) begin
         failures++;
         $display("FAIL pix_count err=%0d expected 1", err_count);
      end
      wait_fd(ok, n);
      checks++;
      if (!ok || frame_ok !== 1'b0) begin
         failures++;
         $display("FAIL pix_frame_bad frame_ok=%b expected 0", frame_ok);
      end
      wait_fd(ok, n);
      checks++;
      if (!ok || frame_ok !== 1'b1 || err_count !== 16'd1) begin
         failures++;
         $display("FAIL pix_frame_next frame_ok=%b err=%0d expected 1 1", frame_ok, err_count);
      end
   endtask

   task automatic test_hsync_slip();
      bit ok;
      run_to(0, 1, ok);
      slip_v = 3;
      run_to(HA - 1, 3, ok);
      checks++;
      if (!ok || locked !== 1'b1) begin
         failures++;
         $display("FAIL slip_before locked=%b expected 1", locked);
      end
      step();
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL slip_drop locked=%b expected 0", locked);
      end
      run_to(HT - 1, VA - 1, ok);
      slip_v = -1;
      checks++;
      if (!ok || locked !== 1'b0) begin
         failures++;
         $display("FAIL slip_wait locked=%b expected 0", locked);
      end
      step();
      checks++;
      if (locked !== 1'b1 || hpos !== 9'd0 || vpos !== 9'(VA)) begin
         failures++;
         $display("FAIL slip_relock locked=%b hpos=%0d vpos=%0d expected 1 0 %0d",
                  locked, hpos, vpos, VA);
      end
      checks++;
      if (err_count !== 16'd1) begin
         failures++;
         $display("FAIL slip_err err=%0d expected 1", err_count);
      end
   endtask

   task automatic test_vsync_drop();
      bit ok;
      int fd0;
      run_to(0, 1, ok);
      drop_vs = 1;
      run_to(HT - 1, VA - 1, ok);
      checks++;
      if (!ok || locked !== 1'b1) begin
         failures++;
         $display("FAIL vdrop_before locked=%b expected 1", locked);
      end
      step();
      fd0 = fd_seen;
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL vdrop_drop locked=%b expected 0", locked);
      end
      run_to(0, 1, ok);
      drop_vs = 0;
      run_to(HT - 1, VA - 1, ok);
      checks++;
      if (!ok || locked !== 1'b0 || fd_seen != fd0) begin
         failures++;
         $display("FAIL vdrop_unlocked locked=%b frame_done_pulses=%0d expected 0 0",
                  locked, fd_seen - fd0);
      end
      step();
      checks++;
      if (locked !== 1'b1 || vpos !== 9'(VA) || err_count !== 16'd1) begin
         failures++;
         $display("FAIL vdrop_relock locked=%b vpos=%0d err=%0d expected 1 %0d 1",
                  locked, vpos, err_count, VA);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      run_to(HA, 5, ok);
      hold = 1;
      rst = 1'b1;
      step();
      checks++;
      if ({hpos, vpos} !== 18'd0 || {display_on, locked, frame_done, frame_ok} !== 4'b0000 ||
          err_count !== 16'd0) begin
         failures++;
         $display("FAIL rstmid_outputs hpos=%0d vpos=%0d flags=%b err=%0d expected all 0",
                  hpos, vpos, {display_on, locked, frame_done, frame_ok}, err_count);
      end
      step();
      rst = 1'b0;
      repeat (4) step();
      checks++;
      if (hpos !== 9'd0 || locked !== 1'b0 || display_on !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_no_edge hpos=%0d locked=%b display_on=%b expected 0 0 0",
                  hpos, locked, display_on);
      end
      hold = 0;
      run_to(HA, 6, ok);
      checks++;
      if (!ok || hpos !== 9'(HA) || locked !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_edge hpos=%0d locked=%b expected %0d 0", hpos, locked, HA);
      end
      wait_lock(ok);
      checks++;
      if (!ok || err_count !== 16'd0) begin
         failures++;
         $display("FAIL rstmid_relock locked=%b err=%0d expected 1 0", locked, err_count);
      end
   endtask

   task automatic test_saturate();
      int m = 0;
      clr_err = 1'b1;
      force7 = 1;
      for (int i = 0; i < 1000; i++) begin
         step();
         clr_err = 1'b0;
         if (pat(drv_h, drv_v) != 3'b111) m++;
      end
      force7 = 0;
      step();
      step();
      checks++;
      if (err_count !== 16'(m)) begin
         failures++;
         $display("FAIL sat_partial err=%0d expected %0d", err_count, m);
      end
      clr_err = 1'b1;
      force7 = 1;
      for (int i = 0; i < 67000; i++) begin
         step();
         clr_err = 1'b0;
      end
      force7 = 0;
      step();
      step();
      checks++;
      if (err_count !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_full err=%h expected ffff", err_count);
      end
      checks++;
      if (frame_ok !== 1'b0 || locked !== 1'b1) begin
         failures++;
         $display("FAIL sat_status frame_ok=%b locked=%b expected 0 1", frame_ok, locked);
      end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      checks++;
      if (err_count !== 16'd0) begin
         failures++;
         $display("FAIL sat_clear err=%0d expected 0", err_count);
      end
      step();
      checks++;
      if (err_count !== 16'd0) begin
         failures++;
         $display("FAIL sat_after_clear err=%0d expected 0", err_count);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_frame_period();
      test_pixel_error();
      test_hsync_slip();
      test_vsync_drop();
      test_reset_mid();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
